capture_reader: RTL
===================

# capture_reader

Read-side consumer of the double-banked DSO sample buffer. Accepts a completed capture from the acquisition side via a valid/ready handshake, which swaps the buffer banks. Latches the trigger address and streams the frozen bank out in time order: half a bank of pre-trigger samples, then the trigger sample and the post-trigger samples. Output goes through a ready/valid stream with `out_last`. Sits between the buffer RAM read port and the SPI module.

## Interface
- `DEPTH`, 11: buffer address width; msb = bank, low `DEPTH-1` bits = position in bank. Bank size is N = 2^(DEPTH-1).
- `DATA_W`, 8: sample width.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  permits accepting a new capture.
- `cap_valid`  in  1  acquisition side holds a completed capture.
- `cap_ready`  out  1  reader idle and enabled; `cap_valid & cap_ready` swaps banks.
- `trig_addr`  in  DEPTH  {bank, position} of the trigger, registered by the acquisition side on the handshake edge.
- `mem_rd_en`  out  1  buffer RAM read strobe.
- `mem_rd_addr`  out  DEPTH  buffer RAM read address.
- `mem_rd_data`  in  DATA_W  RAM output, valid the cycle after `mem_rd_en`.
- `out_data`  out  DATA_W  streamed sample.
- `out_valid`  out  1  `out_data` valid.
- `out_ready`  in  1  consumer accepts.
- `out_last`  out  1  marks the final (N-th) sample.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- **States:**
  - IDLE: `cap_ready = enable`. On `cap_valid & cap_ready`, go to LOAD.
  - LOAD: one cycle. Latch `bank = trig_addr[DEPTH-1]`. Latch `pos = (trig_addr[DEPTH-2:0] - N/2) mod N`. Clear `issued` and `sent` counters. Go to STREAM.
  - STREAM: issue reads while `issued < N` and (`fifo_count + in_flight < 2`).
  - `mem_rd_addr = {bank, pos}`; `pos` increments mod N after each read. The bank bit never changes during a readout.
  - RAM data is written to a 2-entry FIFO on the cycle after each read. The FIFO head drives `out_data` / `out_valid`.
  - `sent` increments on each `out_valid & out_ready`. `out_last = out_valid & (sent == N-1)`.
  - When the last sample is accepted, go to IDLE.
- `cap_ready` is low in every state except IDLE. `cap_valid` arriving in any other state waits.
- Deasserting `enable` mid-readout does not abort; it only blocks the next handshake.
- Sample order: sample index N/2 is always the trigger sample.
- **Arithmetic:** all position math is DEPTH-1 bits with natural wrap. `sent` and `issued` are DEPTH bits wide, so they can represent N.

## Timing
- **Reset values:** state IDLE, `cap_ready` 0 (while `rst_n` low), `mem_rd_en` 0, `mem_rd_addr` 0, `out_valid` 0, `out_last` 0, `out_data` 0, `busy` 0, FIFO empty.
- **Latency:** handshake in cycle t → LOAD in t+1 → first `mem_rd_en` in t+2 → data in t+3 → `out_valid` from t+4.
- **Throughput:** with `out_ready` held high, one sample per cycle; the last sample is in cycle t+3+N. `cap_ready` returns in cycle t+4+N if `enable` is high.
- **Backpressure:** while `out_ready` is low, `out_data`, `out_valid` and `out_last` hold stable. At most 2 reads are outstanding; no sample is dropped or duplicated.
- `mem_rd_en` is never asserted outside STREAM, and never for more than N reads per capture.
- **Reset mid-readout:** return to IDLE immediately and flush the FIFO. The acquisition side stays waiting and re-handshakes after reset.

## Structure
- The shared package `dso_pkg` holds:
  - state encodings (IDLE = 0, LOAD = 1, STREAM = 2);
  - `PRE_TRIG_FRAC` (fixed at half bank);
  - DATA_W / DEPTH defaults, shared with the acquisition driver.
- Sub-module `rd_fifo2`: 2-entry synchronous FIFO with `count` output, asynchronous active-low reset.

## Test plan
- **Basic readout.** DEPTH=5 (N=16), `trig_addr` = 5'b1_00011, `out_ready` = 1. Required:
  - `mem_rd_addr` sequence 27..31, 16..26;
  - `out_valid` first at t+4;
  - `out_last` on the 16th sample;
  - RAM preloaded with data = address, so `out_data` matches the addresses.
- **Wrap at zero.** `trig_addr` = 5'b0_00000 → addresses 8..15, 0..7. The 9th output is the sample from address 0.
- **Backpressure.** `out_ready` toggled randomly at 50%. Required:
  - exactly 16 transfers, in order;
  - outputs stable while stalled;
  - at most 2 outstanding reads;
  - `cap_ready` stays 0 until the last sample is accepted.
- **Enable gating.** `cap_valid` = 1 with `enable` = 0 → `cap_ready` stays 0 and no reads are issued. When `enable` rises, the handshake occurs the same cycle.
- **Back-to-back captures.** `cap_valid` is held high. The second handshake must occur exactly 1 cycle after the first readout's last transfer (`out_ready` = 1), using the new `trig_addr` bank.
- **Reset mid-stream.** Assert `rst_n` = 0 after 5 samples. Required:
  - all outputs go to their reset values asynchronously;
  - after release, a new handshake streams a full 16-sample capture from its start.

Source files
------------

// File: rtl/dso_pkg.sv
// Shared definitions for the DSO sample-buffer datapath.
//   state_t        : reader FSM encoding (IDLE = 0, LOAD = 1, STREAM = 2)
//   PRE_TRIG_FRAC  : bank size divided by this gives the pre-trigger sample count
//   DEPTH_DEF      : default buffer address width ({bank, position})
//   DATA_W_DEF     : default sample width
// The acquisition driver uses the same defaults.
package dso_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STREAM = 2'd2
  } state_t;

  localparam int DEPTH_DEF     = 11;
  localparam int DATA_W_DEF    = 8;
  localparam int PRE_TRIG_FRAC = 2;

  // Number of samples that precede the trigger in a readout of a 2^(depth-1) bank.
  function automatic int pre_trig_len(input int depth);
    return (1 << (depth - 1)) / PRE_TRIG_FRAC;
  endfunction

endpackage

// File: rtl/rd_fifo2.sv
// Two-entry synchronous FIFO that decouples buffer-RAM read latency from the
// output stream.
//   clk, rst_n : clock, asynchronous active-low reset (flushes the FIFO)
//   wr_en      : push wr_data (ignored when full unless a pop happens too)
//   wr_data    : data to push
//   rd_en      : pop the head (ignored when empty)
//   rd_data    : current head entry
//   count      : number of stored entries, 0..2
module rd_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         do_wr;
  logic         do_rd;

  assign do_rd   = rd_en && (count != 2'd0);
  // A push into a full FIFO is allowed only when the head leaves on the same edge.
  assign do_wr   = wr_en && ((count != 2'd2) || do_rd);
  assign rd_data = mem[rd_ptr];

  // NOTE: sequential state is written with <= so every flop samples the
  // pre-edge values; blocking = here would make results depend on statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: storage is reset only because it is two flops and the head drives
      // a port that must read 0 in reset; real RAM arrays are left unreset.
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_wr) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_rd) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/capture_reader.sv
// Read-side consumer of the double-banked DSO sample buffer.
// Takes a completed capture over a valid/ready handshake (which swaps banks),
// latches the trigger address and streams the frozen bank in time order:
// N/2 pre-trigger samples, then the trigger sample and the post-trigger ones.
//   clk, rst_n   : clock, asynchronous active-low reset
//   enable       : permits accepting a new capture
//   cap_valid    : acquisition side holds a completed capture
//   cap_ready    : idle and enabled; cap_valid & cap_ready swaps banks
//   trig_addr    : {bank, position} of the trigger, stable during LOAD
//   mem_rd_en    : buffer RAM read strobe
//   mem_rd_addr  : buffer RAM read address {bank, position}
//   mem_rd_data  : RAM output, valid the cycle after mem_rd_en
//   out_data     : streamed sample
//   out_valid    : out_data valid
//   out_ready    : consumer accepts
//   out_last     : marks the N-th sample of the readout
//   busy         : high in any state other than IDLE
module capture_reader
  import dso_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              cap_valid,
  output logic              cap_ready,
  input  logic [DEPTH-1:0]  trig_addr,
  output logic              mem_rd_en,
  output logic [DEPTH-1:0]  mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy
);

  localparam int               PW       = DEPTH - 1;
  localparam int               N        = 1 << PW;
  localparam logic [DEPTH-1:0] N_CNT    = DEPTH'(N);
  localparam logic [DEPTH-1:0] LAST_CNT = DEPTH'(N - 1);
  localparam logic [DEPTH-1:0] ONE_CNT  = DEPTH'(1);
  localparam logic [PW-1:0]    PRE_POS  = PW'(pre_trig_len(DEPTH));
  localparam logic [PW-1:0]    ONE_POS  = PW'(1);

  state_t            state;
  logic              bank;
  logic [PW-1:0]     pos;
  logic [DEPTH-1:0]  issued;
  logic [DEPTH-1:0]  sent;
  logic              rd_pend;   // RAM data for last cycle's read is on mem_rd_data
  logic              ready_q;   // registered "in IDLE", low while in reset
  logic              busy_q;
  logic [1:0]        fifo_count;
  logic              pop;
  logic [2:0]        occ;

  assign out_valid   = (fifo_count != 2'd0);
  assign pop         = out_valid && out_ready;
  assign cap_ready   = ready_q && enable;
  assign busy        = busy_q;
  assign mem_rd_addr = {bank, pos};
  assign out_last    = out_valid && (sent == LAST_CNT);

  // FIFO occupancy once this cycle's returning data and this cycle's pop have
  // settled. A new read lands one cycle later, so issuing only while this is
  // below 2 can never overflow, yet still allows one read per cycle when the
  // consumer drains every cycle.
  assign occ = {1'b0, fifo_count} + {2'b00, rd_pend} - {2'b00, pop};

  assign mem_rd_en = (state == STREAM) && (issued < N_CNT) && (occ < 3'd2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      bank    <= 1'b0;
      pos     <= '0;
      issued  <= '0;
      sent    <= '0;
      rd_pend <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      rd_pend <= mem_rd_en;
      case (state)
        IDLE: begin
          if (cap_valid && cap_ready) begin
            state   <= LOAD;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end else begin
            ready_q <= 1'b1;
          end
        end
        LOAD: begin
          bank   <= trig_addr[DEPTH-1];
          // Start N/2 samples before the trigger; wraps naturally within the bank.
          pos    <= trig_addr[DEPTH-2:0] - PRE_POS;
          issued <= '0;
          sent   <= '0;
          state  <= STREAM;
        end
        STREAM: begin
          if (mem_rd_en) begin
            pos    <= pos + ONE_POS;
            issued <= issued + ONE_CNT;
          end
          if (pop) begin
            sent <= sent + ONE_CNT;
            if (sent == LAST_CNT) begin
              state   <= IDLE;
              ready_q <= 1'b1;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  rd_fifo2 #(.W(DATA_W)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (rd_pend),
    .wr_data (mem_rd_data),
    .rd_en   (pop),
    .rd_data (out_data),
    .count   (fifo_count)
  );

endmodule
